// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUSel codes served by the divider and the divider FSM state type.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

  localparam logic [3:0] ALU_DIV = 4'b1000;
  localparam logic [3:0] ALU_MOD = 4'b1001;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift in the next dividend bit and conditionally subtract.
// Latency: combinational.
// Backpressure: none.
// Ports: rem_in (partial remainder), dvd_msb (next dividend bit), divisor -> rem_out, q_bit.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_in,
  input  logic         dvd_msb,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0]   trial;
  logic [W-1:0] diff;

  // Compare at W+1 bits so a partial remainder that overflowed W bits still subtracts.
  assign trial   = {rem_in, dvd_msb};
  assign diff    = trial[W-1:0] - divisor;
  assign q_bit   = (trial >= {1'b0, divisor});
  assign rem_out = q_bit ? diff : trial[W-1:0];

endmodule

// File: rtl/alu_div_unit.sv
// Multi-cycle radix-2 restoring divider giving quotient and remainder for ALU DIV/MOD.
// Latency: DIVw edges after accept to DONE (divValid the following cycle); divide-by-zero goes to DONE on the accept edge.
// Backpressure: divReady high only in IDLE; divStart outside IDLE is dropped, never queued.
// Ports: clk, rst (sync, active-high), divStart/divA/divB/divSigned in; divReady, divValid, divQuot, divRem out.
// Optional feature: define SIGNED_DIV_EN to honour divSigned (RISC-V DIV/REM semantics); otherwise all unsigned.
module alu_div_unit
  import alu_pkg::*;
#(
  parameter int DIVw = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            divStart,
  input  logic [DIVw-1:0] divA,
  input  logic [DIVw-1:0] divB,
  input  logic            divSigned,
  output logic            divReady,
  output logic            divValid,
  output logic [DIVw-1:0] divQuot,
  output logic [DIVw-1:0] divRem
);

  localparam int CW = $clog2(DIVw);

  div_state_t      state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [DIVw-1:0] dvd;   // dividend shifts out MSB-first while quotient bits shift in at the LSB
  logic [DIVw-1:0] dvs;
  logic [DIVw-1:0] rem;
  logic [DIVw-1:0] step_rem;
  logic            step_q;
  logic [DIVw-1:0] q_fin;
  logic [DIVw-1:0] a_mag, b_mag;
  logic [DIVw-1:0] q_out, r_out;

  div_step #(.W(DIVw)) u_step (
    .rem_in  (rem),
    .dvd_msb (dvd[DIVw-1]),
    .divisor (dvs),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Quotient as it stands after the iteration happening this cycle.
  assign q_fin = {dvd[DIVw-2:0], step_q};

`ifdef SIGNED_DIV_EN
  logic a_neg, b_neg, neg_q, neg_r;

  assign a_neg = divSigned & divA[DIVw-1];
  assign b_neg = divSigned & divB[DIVw-1];
  assign a_mag = a_neg ? -divA : divA;
  assign b_mag = b_neg ? -divB : divB;
  // MIN_INT / -1 falls out naturally: magnitude quotient 2^(W-1) negates to itself, remainder 0.
  assign q_out = neg_q ? -q_fin : q_fin;
  assign r_out = neg_r ? -step_rem : step_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && divStart) begin
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
    end
  end
`else
  logic unused_signed;

  assign unused_signed = divSigned;
  assign a_mag = divA;
  assign b_mag = divB;
  assign q_out = q_fin;
  assign r_out = step_rem;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (divStart) state_nxt = (divB == '0) ? DONE : CALC;
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign divReady = (state == IDLE);
  assign divValid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      rem     <= '0;
      divQuot <= '0;
      divRem  <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (divStart) begin
            dvd <= a_mag;
            dvs <= b_mag;
            rem <= '0;
            cnt <= CW'(DIVw - 1);
            // Zero divisor skips CALC; all-ones quotient equals -1 in the signed build too.
            if (divB == '0) begin
              divQuot <= '1;
              divRem  <= divA;
            end
          end
        end
        CALC: begin
          rem <= step_rem;
          dvd <= q_fin;
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            divQuot <= q_out;
            divRem  <= r_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_unit.sv
// Directed bench for alu_div_unit: hand-computed quotient/remainder, latency, ready/valid and abort checks.
// Latency is counted as clock edges after the accepting edge until divValid is seen (DIVw normally, 0 for /0).
// Summary line reports comparisons run and failed.
module tb_alu_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         divStart;
  logic [W-1:0] divA, divB;
  logic         divSigned;
  logic         divReady, divValid;
  logic [W-1:0] divQuot, divRem;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_div_unit #(.DIVw(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .divStart  (divStart),
    .divA      (divA),
    .divB      (divB),
    .divSigned (divSigned),
    .divReady  (divReady),
    .divValid  (divValid),
    .divQuot   (divQuot),
    .divRem    (divRem)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request and watch 60 cycles. poke_at >= 0 drives a second start at that cycle.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input int poke_at,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output int lat, output int pulses, output int rdy_bad);
    int g;
    g = 0;
    @(negedge clk);
    while (!divReady && g < 100) begin
      @(negedge clk);
      g++;
    end
    divA = a; divB = b; divSigned = s; divStart = 1'b1;
    @(posedge clk);
    #1;
    divStart = 1'b0;
    divA = ~a; divB = ~b;     // operands must have been captured on the accept edge
    lat = -1; pulses = 0; rdy_bad = 0; q = '0; r = '0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (divValid) begin
        pulses++;
        if (lat < 0) begin
          lat = n; q = divQuot; r = divRem;
        end
      end
      if ((lat < 0 || n == lat) && divReady) rdy_bad++;
      if (lat >= 0 && n == lat + 1 && !divReady) rdy_bad++;
      if (n == poke_at) begin
        divA = 32'd77; divB = 32'd3; divStart = 1'b1;
      end
      @(posedge clk);
      #1;
      divStart = 1'b0;
    end
  endtask

  task automatic one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                     input logic [W-1:0] eq, input logic [W-1:0] er, input int elat);
    logic [W-1:0] q, r;
    int lat, pulses, rdy_bad;
    run_div(a, b, s, -1, q, r, lat, pulses, rdy_bad);
    check({tag, "_q"}, q, eq);
    check({tag, "_r"}, r, er);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_ready"}, rdy_bad, 0);
  endtask

  initial begin
    logic [W-1:0] q, r;
    int lat, pulses, rdy_bad, vcount;

    rst = 1'b1; divStart = 1'b0; divA = '0; divB = '0; divSigned = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", divReady, 1);
    check("rst_valid", divValid, 0);
    check("rst_quot", divQuot, 0);
    check("rst_rem", divRem, 0);
    rst = 1'b0;

    // Basic unsigned and boundary operands.
    one("d100_7",  32'd100,      32'd7, 1'b0, 32'd14,       32'd2,      W);
    @(negedge clk);
    check("hold_quot", divQuot, 32'd14);
    check("hold_rem", divRem, 32'd2);
    one("dmax_1",  32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0,      W);
    one("d5_9",    32'd5,        32'd9, 1'b0, 32'd0,        32'd5,      W);
    one("div0",    32'h1234,     32'd0, 1'b0, 32'hFFFFFFFF, 32'h1234,   0);

    // Start during CALC must be ignored.
    run_div(32'd1000, 32'd10, 1'b0, 5, q, r, lat, pulses, rdy_bad);
    check("busy_q", q, 32'd100);
    check("busy_r", r, 32'd0);
    check("busy_pulses", pulses, 1);
    check("busy_lat", lat, W);

    // Reset during iteration 10 aborts with no divValid.
    @(negedge clk);
    divA = 32'hFFFF0000; divB = 32'd3; divSigned = 1'b0; divStart = 1'b1;
    @(posedge clk);
    #1;
    divStart = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", divReady, 1);
    check("abort_quot", divQuot, 0);
    check("abort_rem", divRem, 0);
    vcount = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (divValid) vcount++;
    end
    check("abort_novalid", vcount, 0);
    one("d20_6",   32'd20,       32'd6, 1'b0, 32'd3,        32'd2,      W);

    // Unsigned interpretation of signed-looking operands.
    one("u_m7_2",  32'hFFFFFFF9, 32'd2,        1'b0, 32'h7FFFFFFC, 32'd1,        W);
    one("u_7_m2",  32'd7,        32'hFFFFFFFE, 1'b0, 32'd0,        32'd7,        W);
    one("u_min_m1",32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000, W);
    one("s_div0",  32'hFFFFFFFB, 32'd0,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, 0);
`ifdef SIGNED_DIV_EN
    one("s_m7_2",  32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, W);
    one("s_7_m2",  32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1,        W);
    one("s_min_m1",32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        W);
`else
    // divSigned has no effect without the signed feature.
    one("s_m7_2",  32'hFFFFFFF9, 32'd2,        1'b1, 32'h7FFFFFFC, 32'd1,        W);
    one("s_7_m2",  32'd7,        32'hFFFFFFFE, 1'b1, 32'd0,        32'd7,        W);
    one("s_min_m1",32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0,        32'h80000000, W);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
